// File: rtl/icache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icache_pkg : shared types, address-geometry helpers for the icache         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam int OFFSET_BITS = 2;
  localparam int WORD_LSB    = OFFSET_BITS;

  function automatic int index_lsb(input int words_per_line);
    return WORD_LSB + $clog2(words_per_line);
  endfunction

  function automatic int tag_lsb(input int nb_lines, input int words_per_line);
    return index_lsb(words_per_line) + $clog2(nb_lines);
  endfunction

  // Line base address: clear word and byte-offset bits below line_lsb.
  function automatic logic [31:0] line_base(input logic [31:0] adr, input int line_lsb);
    return adr & ~((32'd1 << line_lsb) - 32'd1);
  endfunction

endpackage : icache_pkg
`default_nettype wire

// File: rtl/icache_refill_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icache_refill_fsm : line refill sequencer and memory request/ack handshake |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter int LINE_LSB       = 4,
  localparam int WORD_BITS     = $clog2(WORDS_PER_LINE)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 invalidate,
  input  logic [31:0]          adr,
  input  logic                 mem_ack,
  output state_t               state,
  output logic                 mem_req,
  output logic [31:0]          mem_adr,
  output logic                 wr_en,
  output logic [WORD_BITS-1:0] wr_word,
  output logic                 line_done
);

  localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(WORDS_PER_LINE - 1);

  logic discard;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      wr_word <= '0;
      discard <= 1'b0;
      mem_req <= 1'b0;
      mem_adr <= '0;
    end else begin
      case (state)
        IDLE: begin
          discard <= 1'b0;
          if (start) begin
            state   <= REFILL;
            wr_word <= '0;
            mem_req <= 1'b1;
            mem_adr <= line_base(adr, LINE_LSB);
          end
        end
        REFILL: begin
          if (invalidate) discard <= 1'b1;
          if (mem_ack) begin
            if (wr_word == LAST_WORD) begin
              state   <= UPDATE;
              mem_req <= 1'b0;
            end else begin
              // address stays inside the line so the top can index the fill with it
              wr_word <= wr_word + WORD_BITS'(1);
              mem_adr <= mem_adr + 32'd4;
            end
          end
        end
        UPDATE: begin
          state   <= IDLE;
          discard <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wr_en     = (state == REFILL) & mem_ack;
  // Commit strobe: suppressed if an invalidate arrived during or at the end of the fill.
  assign line_done = (state == UPDATE) & ~discard & ~invalidate;

endmodule : icache_refill_fsm
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icache : direct-mapped read-only instruction cache, same-cycle hits.       |
// | Optional macro ICACHE_PERF_CNT_EN adds hit/miss counters.  Rev 1.0         |
// +----------------------------------------------------------------------------+
module icache
  import icache_pkg::*;
#(
  parameter int NB_LINES       = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ADR_SI,
  input  logic        ADR_VALID_SI,
  output logic [31:0] IC_INST_SI,
  output logic        IC_STALL_SI,
  input  logic        INVALIDATE_SI,
  output logic [31:0] MEM_ADR_SC,
  output logic        MEM_REQ_SC,
  input  logic [31:0] MEM_DATA_SM,
  input  logic        MEM_ACK_SM
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] HIT_CNT_SC,
  output logic [31:0] MISS_CNT_SC
`endif
);

  localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
  localparam int IDX_BITS  = $clog2(NB_LINES);
  localparam int IDX_LSB   = index_lsb(WORDS_PER_LINE);
  localparam int TAG_LSB   = tag_lsb(NB_LINES, WORDS_PER_LINE);
  localparam int TAG_BITS  = 32 - TAG_LSB;

  logic [NB_LINES-1:0] valid;
  logic [TAG_BITS-1:0] tags [NB_LINES];
  logic [31:0]         data [NB_LINES][WORDS_PER_LINE];

  state_t               state;
  logic                 wr_en;
  logic                 line_done;
  logic [WORD_BITS-1:0] wr_word;
  logic                 hit;
  logic                 start;

  logic [IDX_BITS-1:0]  idx;
  logic [WORD_BITS-1:0] word;
  logic [TAG_BITS-1:0]  tag;
  logic [IDX_BITS-1:0]  fill_idx;
  logic [TAG_BITS-1:0]  fill_tag;
  logic                 unused_bits;

  assign idx         = ADR_SI[IDX_LSB +: IDX_BITS];
  assign word        = ADR_SI[WORD_LSB +: WORD_BITS];
  assign tag         = ADR_SI[31:TAG_LSB];
  assign fill_idx    = MEM_ADR_SC[IDX_LSB +: IDX_BITS];
  assign fill_tag    = MEM_ADR_SC[31:TAG_LSB];
  assign unused_bits = ^{ADR_SI[WORD_LSB-1:0], MEM_ADR_SC[IDX_LSB-1:0]};

  assign hit         = ADR_VALID_SI & valid[idx] & (tags[idx] == tag) & (state == IDLE);
  assign start       = ADR_VALID_SI & ~hit & (state == IDLE);
  assign IC_INST_SI  = hit ? data[idx][word] : 32'd0;
  assign IC_STALL_SI = (ADR_VALID_SI & ~hit) | (state != IDLE);

  icache_refill_fsm #(
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .LINE_LSB       (IDX_LSB)
  ) u_refill_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .invalidate (INVALIDATE_SI),
    .adr        (ADR_SI),
    .mem_ack    (MEM_ACK_SM),
    .state      (state),
    .mem_req    (MEM_REQ_SC),
    .mem_adr    (MEM_ADR_SC),
    .wr_en      (wr_en),
    .wr_word    (wr_word),
    .line_done  (line_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
    end else if (INVALIDATE_SI) begin
      valid <= '0;
    end else if (line_done) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (line_done) tags[fill_idx] <= fill_tag;
    if (wr_en)     data[fill_idx][wr_word] <= MEM_DATA_SM;
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      HIT_CNT_SC  <= '0;
      MISS_CNT_SC <= '0;
    end else begin
      if (hit)   HIT_CNT_SC  <= HIT_CNT_SC + 32'd1;
      if (start) MISS_CNT_SC <= MISS_CNT_SC + 32'd1;
    end
  end
`endif

endmodule : icache
`default_nettype wire
